mem_port_arbiter: RTL

- Shares one unified memory port (en/addr/wdata/write-strobe/rdata/valid) between two requesters: instruction fetch (IF, read-only) and the load/store path of the MEM stage (LS).
- Sits between the core pipeline and the single-ported memory.
- Round-robin arbitration on simultaneous requests, with the grant locked until the memory completes the access.
- Watchdog releases the port and flags an error if the memory never answers.

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/mem_arb_watchdog.sv | 23 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state, port owner,
// the muxed request bundle and the debug snapshot of the arbitration FSM.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  write;
  } mem_req_t;

  typedef struct packed {
    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last;
  } arb_dbg_t;

  // Round-robin pick: on a tie the requester that was not served last wins.
  function automatic arb_owner_t rr_pick(input logic if_en, input logic ls_en,
                                         input arb_owner_t last);
    arb_owner_t pick;
    pick = OWN_NONE;
    if (if_en && ls_en) pick = (last == OWN_IF) ? OWN_LS : OWN_IF;
    else if (if_en)     pick = OWN_IF;
    else if (ls_en)     pick = OWN_LS;
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Outstanding-access age counter; expired is high once the count reaches
// TIMEOUT cycles since the access was issued.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i || clear) cnt_q <= '0;
    else if (cnt_en)    cnt_q <= cnt_q + 1'b1;
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (read-only) and
// the load/store path, with round-robin arbitration and a watchdog abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        if_en_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_valid_o,
  input  logic        ls_en_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_data_i,
  input  logic [3:0]  ls_write_i,
  output logic [31:0] ls_data_o,
  output logic        ls_valid_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_write_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i,
  output logic        timeout_o,
  output logic        busy_o,
  output arb_dbg_t    dbg_o
);

  // Handshake: a requester raises en with stable addr/data and holds it until
  // its one-cycle valid pulse (read data is only meaningful in that cycle);
  // dropping en early abandons the access. On the memory side, any cycle with
  // mem_en_o and mem_valid_i both high completes the access.

  arb_state_t state_q;
  arb_owner_t owner_q;
  arb_owner_t last_q;
  arb_owner_t winner;
  arb_owner_t sel;
  mem_req_t   if_req;
  mem_req_t   ls_req;
  mem_req_t   sel_req;
  logic       expired;
  logic       abort;
  logic       done;
  logic       waiting;

  assign if_req = '{en: if_en_i, addr: if_addr_i, data: 32'h0, write: 4'h0};
  assign ls_req = '{en: ls_en_i, addr: ls_addr_i, data: ls_data_i, write: ls_write_i};

  always_comb begin
    winner = rr_pick(if_en_i, ls_en_i, last_q);
    sel    = (state_q == IDLE) ? winner : owner_q;
    case (sel)
      OWN_IF:  sel_req = if_req;
      OWN_LS:  sel_req = ls_req;
      default: sel_req = '0;
    endcase
  end

  assign abort   = (state_q == BUSY) && sel_req.en && expired && !rst_i;
  assign done    = mem_en_o && mem_valid_i;
  assign waiting = mem_en_o && !mem_valid_i;

  assign mem_en_o    = sel_req.en && !abort && !rst_i;
  assign mem_addr_o  = sel_req.addr;
  assign mem_data_o  = sel_req.data;
  assign mem_write_o = sel_req.write;

  assign if_valid_o = done && (sel == OWN_IF);
  assign ls_valid_o = done && (sel == OWN_LS);
  assign if_data_o  = mem_data_i;
  assign ls_data_o  = mem_data_i;
  assign timeout_o  = abort;
  assign busy_o     = (state_q == BUSY);
  assign dbg_o      = '{state: state_q, owner: owner_q, last: last_q};

  // Counter only runs while an issued access is unanswered; every other
  // cycle (idle, completion, flush, abort) leaves it at zero.
  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_i   (rst_i),
    .clear   (!waiting),
    .cnt_en  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      last_q  <= OWN_IF;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_en_o) begin
            if (mem_valid_i) begin
              last_q <= winner;
            end else begin
              state_q <= BUSY;
              owner_q <= winner;
            end
          end
        end
        BUSY: begin
          if (!sel_req.en) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
          end else if (abort || mem_valid_i) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            last_q  <= owner_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
